// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply RAM subsystem: widths, port IDs,
// arbitration-state encoding and the A/B/R region base addresses.
package mm_pkg;

  localparam int MM_ADDR_WIDTH = 10;
  localparam int MM_DATA_WIDTH = 8;

  localparam logic PORT_HOST = 1'b0;
  localparam logic PORT_ENG  = 1'b1;

  localparam logic [MM_ADDR_WIDTH-1:0] MM_A_BASE = 10'h000;
  localparam logic [MM_ADDR_WIDTH-1:0] MM_B_BASE = 10'h100;
  localparam logic [MM_ADDR_WIDTH-1:0] MM_R_BASE = 10'h200;

  typedef enum logic [1:0] {
    ARB_FREE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  function automatic logic port_other(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/mm_arb_grant.sv
// Grant logic for the two-port RAM arbiter: lock ownership FSM, bounded lock
// counter and last-grant memory for round-robin tie breaking.
module mm_arb_grant
  import mm_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int LOCK_MAX  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_lock0,
  input  logic i_lock1,
  output logic o_gnt0,
  output logic o_gnt1
);

  arb_state_e r_state, w_state_nxt;
  logic [7:0] r_lock_cnt, w_lock_cnt_nxt, w_cnt_inc;
  logic       r_last_gnt, w_last_gnt_nxt;
  logic       r_force, w_force_nxt;
  logic       w_own0, w_own1, w_tie_port;
  logic       w_acc, w_port, w_lock, w_same_owner;

  // An owner that stops requesting no longer blocks the other port.
  always_comb begin
    w_own0     = (r_state == ARB_OWN0) && i_req0;
    w_own1     = (r_state == ARB_OWN1) && i_req1;
    w_tie_port = (PRIO_MODE == 1 && !r_force) ? PORT_HOST : port_other(r_last_gnt);
    o_gnt0     = 1'b0;
    o_gnt1     = 1'b0;
    if (w_own0) begin
      o_gnt0 = 1'b1;
    end else if (w_own1) begin
      o_gnt1 = 1'b1;
    end else if (i_req0 && i_req1) begin
      o_gnt0 = (w_tie_port == PORT_HOST);
      o_gnt1 = (w_tie_port == PORT_ENG);
    end else begin
      o_gnt0 = i_req0;
      o_gnt1 = i_req1;
    end
  end

  always_comb begin
    w_acc          = o_gnt0 | o_gnt1;
    w_port         = o_gnt1 ? PORT_ENG : PORT_HOST;
    w_lock         = o_gnt1 ? i_lock1 : i_lock0;
    w_same_owner   = ((r_state == ARB_OWN0) && o_gnt0) || ((r_state == ARB_OWN1) && o_gnt1);
    w_cnt_inc      = w_same_owner ? (r_lock_cnt + 8'd1) : 8'd1;
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_last_gnt_nxt = r_last_gnt;
    w_force_nxt    = 1'b0;
    if (w_acc) begin
      w_last_gnt_nxt = w_port;
      if (!w_lock) begin
        w_state_nxt    = ARB_FREE;
        w_lock_cnt_nxt = 8'd0;
      end else if (w_cnt_inc >= 8'(LOCK_MAX)) begin
        // Exhausted hold: the other port gets the very next tie.
        w_state_nxt    = ARB_FREE;
        w_lock_cnt_nxt = 8'd0;
        w_force_nxt    = 1'b1;
      end else begin
        w_state_nxt    = o_gnt1 ? ARB_OWN1 : ARB_OWN0;
        w_lock_cnt_nxt = w_cnt_inc;
      end
    end else begin
      w_state_nxt    = ARB_FREE;
      w_lock_cnt_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ARB_FREE;
      r_lock_cnt <= 8'd0;
      r_last_gnt <= PORT_ENG;
      r_force    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_force    <= w_force_nxt;
    end
  end

endmodule

// File: rtl/mm_ram_arbiter.sv
// Shares the single-port matrix RAM between the host loader (port 0) and the
// matrix engine (port 1); registers the RAM bus and returns reads 2 cycles on.
module mm_ram_arbiter
  import mm_pkg::*;
#(
  parameter int ADDR_WIDTH = MM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MM_DATA_WIDTH,
  parameter int PRIO_MODE  = 0,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic                  p0_lock,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic                  p1_lock,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  logic                  w_gnt0, w_gnt1, w_acc, w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  r_ram_we;
  logic                  r_vld_p0, r_port_p0, r_vld_p1, r_port_p1;

  mm_arb_grant #(
    .PRIO_MODE (PRIO_MODE),
    .LOCK_MAX  (LOCK_MAX)
  ) u_grant (
    .clk     (clk),
    .reset   (reset),
    .i_req0  (p0_req),
    .i_req1  (p1_req),
    .i_lock0 (p0_lock),
    .i_lock1 (p1_lock),
    .o_gnt0  (w_gnt0),
    .o_gnt1  (w_gnt1)
  );

  assign w_acc   = w_gnt0 | w_gnt1;
  assign w_we    = w_gnt1 ? p1_we    : p0_we;
  assign w_addr  = w_gnt1 ? p1_addr  : p0_addr;
  assign w_wdata = w_gnt1 ? p1_wdata : p0_wdata;

  // p0: accept edge registers the bus; p1: RAM has sampled, ram_q is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_we   <= 1'b0;
      r_vld_p0   <= 1'b0;
      r_port_p0  <= PORT_HOST;
      r_vld_p1   <= 1'b0;
      r_port_p1  <= PORT_HOST;
    end else begin
      r_ram_we  <= w_acc & w_we;
      if (w_acc) begin
        r_ram_addr <= w_addr;
        r_ram_data <= w_wdata;
      end
      r_vld_p0  <= w_acc & ~w_we;
      r_port_p0 <= w_gnt1;
      r_vld_p1  <= r_vld_p0;
      r_port_p1 <= r_port_p0;
    end
  end

  assign p0_gnt    = w_gnt0;
  assign p1_gnt    = w_gnt1;
  assign ram_addr  = r_ram_addr;
  assign ram_data  = r_ram_data;
  assign ram_we    = r_ram_we;
  assign p0_rvalid = r_vld_p1 & (r_port_p1 == PORT_HOST);
  assign p1_rvalid = r_vld_p1 & (r_port_p1 == PORT_ENG);
  assign p0_rdata  = p0_rvalid ? ram_q : '0;
  assign p1_rdata  = p1_rvalid ? ram_q : '0;

endmodule

// File: doc/mm_ram_arbiter.md
# mm_ram_arbiter

Two-port arbiter sharing the single-port matrix RAM (8-bit words, 10-bit addresses, registered read) between a host loader port and the matrix-multiply engine port. It registers the winning request onto the RAM bus and returns read data with a fixed latency. It supports locked bursts with a bounded hold so neither requester starves. It sits between the host/testbench loader, the compute engine and the single RAM instance holding A, B and R.

## Interface
- ADDR_WIDTH, 10, RAM word-address width
- DATA_WIDTH, 8, RAM word width
- PRIO_MODE, 0, 0 = round-robin, 1 = port 0 fixed priority
- LOCK_MAX, 16, max consecutive locked accepts before forced release (1..255)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- p0_req, p1_req  in  1  request valid; held with fields stable until accepted
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_lock, p1_lock  in  1  keep grant for next request while asserted
- p0_addr, p1_addr  in  ADDR_WIDTH  word address
- p0_wdata, p1_wdata  in  DATA_WIDTH  write data
- p0_gnt, p1_gnt  out  1  combinational accept; transfer occurs on edge where req&&gnt
- p0_rvalid, p1_rvalid  out  1  one-cycle pulse, read data valid
- p0_rdata, p1_rdata  out  DATA_WIDTH  read data, valid only with rvalid
- ram_addr  out  ADDR_WIDTH  registered RAM address
- ram_data  out  DATA_WIDTH  registered RAM write data
- ram_we  out  1  registered RAM write enable
- ram_q  in  DATA_WIDTH  RAM registered read output

## Operation
- At most one gnt high per cycle; gnt only asserted to a requesting port.
- Arbitration states: FREE, OWN0, OWN1 (lock ownership). In FREE: if one port requests, grant it; if both: PRIO_MODE=1 -> port 0; PRIO_MODE=0 -> port not in last_gnt.
- In OWNx: port x has absolute grant while x_req. Leave to FREE when x_lock deasserts on an accept, x_req drops, or lock_cnt reaches LOCK_MAX.
- Enter OWNx on an accept with x_lock=1; lock_cnt loads 1; increments per locked accept.
- LOCK_MAX exhaustion: return to FREE and the other port, if requesting, wins the next cycle regardless of PRIO_MODE.
- On accept: ram_addr<=addr, ram_data<=wdata, ram_we<=we, last_gnt<=port. No accept: ram_we<=0, ram_addr/ram_data hold.
- Read tag pipeline (2 stages: valid, port id) tracks reads only; writes produce no rvalid.
- rdata for both ports is ram_q, gated by the matching rvalid.

## Timing
- Reset values: ram_addr=0, ram_data=0, ram_we=0, rvalid both 0, state FREE, lock_cnt=0, last_gnt=1 (port 0 wins first tie).
- Read latency: accept at edge E; RAM samples at E+1; rvalid high for the cycle after E+1, i.e. 2 cycles after the accept edge.
- Throughput: one accept per cycle, back-to-back reads pipelined, alternating ports allowed.
- Write to addr followed next cycle by read of same addr returns the new data.
- Simultaneous req from owner and non-owner in OWNx: owner wins; non-owner gnt stays 0.
- Reset mid-operation: ram_we drops to 0 immediately (asynchronously); in-flight reads discarded, no rvalid after release.
- Request dropped without gnt is legal; no transfer, no state change.

## Structure
- Shared package mm_pkg: ADDR_WIDTH/DATA_WIDTH defaults, port IDs (PORT_HOST=0, PORT_ENG=1), arbitration-state encoding, A/B/R base-address constants.
- One sub-module: mm_arb_grant, holding the grant logic, state register, lock_cnt and last_gnt. Top-level holds the RAM-bus registers and the read tag pipeline.

## Test plan
- Port 0 write addr 5 = 0x2A, then read addr 5 -> p0_rvalid 2 cycles after read accept, p0_rdata=0x2A, p1_rvalid never high.
- Both ports request reads every cycle, PRIO_MODE=0 -> gnt alternates 0,1,0,1 starting with port 0; each rvalid appears on the correct port, 2 cycles after its accept.
- PRIO_MODE=1, both requesting continuously without lock -> port 0 granted every cycle, port 1 never granted until p0_req drops.
- Port 1 locked burst with LOCK_MAX=4 while port 0 requests -> 4 consecutive p1 accepts, then p0_gnt next cycle.
- Assert reset for 1 cycle between a read accept and its rvalid -> ram_we=0 immediately; no rvalid after release; first post-reset tie goes to port 0.
